// File: rtl/tetris_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tetris_pkg
//  Description : Shared board geometry, line-clear controller state encoding,
//                score table and small helper functions.
//  Revision    : 1.0 - initial release
// ============================================================================
package tetris_pkg;

    localparam int BOARD_ROWS  = 20;
    localparam int BOARD_COLS  = 10;
    localparam int BOARD_CELLS = 200;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SCAN      = 3'd1,
        ST_FLASH_ON  = 3'd2,
        ST_FLASH_OFF = 3'd3,
        ST_COLLAPSE  = 3'd4,
        ST_DONE      = 3'd5
    } lc_state_t;

    // Points awarded for 1, 2, 3 and 4-or-more rows cleared at once.
    localparam logic [15:0] SCORE_L1 = 16'd1;
    localparam logic [15:0] SCORE_L2 = 16'd3;
    localparam logic [15:0] SCORE_L3 = 16'd5;
    localparam logic [15:0] SCORE_L4 = 16'd8;

    function automatic logic [15:0] score_add(input logic [4:0] n);
        logic [15:0] v;
        case (n)
            5'd0:    v = 16'd0;
            5'd1:    v = SCORE_L1;
            5'd2:    v = SCORE_L2;
            5'd3:    v = SCORE_L3;
            default: v = SCORE_L4;
        endcase
        return v;
    endfunction

    // Widen a per-row flag mask to a per-cell mask (all columns of a row).
    function automatic logic [BOARD_CELLS-1:0] expand_rows(input logic [BOARD_ROWS-1:0] m);
        logic [BOARD_CELLS-1:0] v;
        v = '0;
        for (int r = 0; r < BOARD_ROWS; r++) begin
            v[r*BOARD_COLS +: BOARD_COLS] = {BOARD_COLS{m[r]}};
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/line_clear_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : line_clear_ctrl_if
//  Description : Bus between the game core (master) and the line-clear
//                controller (slave).
//                master -> slave : vs, start, board_in
//                slave -> master : flash, board_out, board_we, busy, done,
//                                  lines, score (only with LINE_CLEAR_SCORE_EN)
//  Revision    : 1.0 - initial release
// ============================================================================
interface line_clear_ctrl_if;
    import tetris_pkg::*;

    logic                   vs;
    logic                   start;
    logic [BOARD_CELLS-1:0] board_in;
    logic [BOARD_CELLS-1:0] flash;
    logic [BOARD_CELLS-1:0] board_out;
    logic                   board_we;
    logic                   busy;
    logic                   done;
    logic [4:0]             lines;
`ifdef LINE_CLEAR_SCORE_EN
    logic [15:0]            score;
`endif

`ifdef LINE_CLEAR_SCORE_EN
    modport master (output vs, start, board_in,
                    input  flash, board_out, board_we, busy, done, lines, score);
    modport slave  (input  vs, start, board_in,
                    output flash, board_out, board_we, busy, done, lines, score);
`else
    modport master (output vs, start, board_in,
                    input  flash, board_out, board_we, busy, done, lines);
    modport slave  (input  vs, start, board_in,
                    output flash, board_out, board_we, busy, done, lines);
`endif

endinterface
`default_nettype wire

// File: rtl/lc_row_detect.sv
`default_nettype none
// ============================================================================
//  Module      : lc_row_detect
//  Description : Combinational full-row detector.
//                i_board      : 200-bit occupancy, bit row*10+col
//                o_full_mask  : bit r set when all 10 cells of row r are set
//                o_full_count : number of set bits in o_full_mask
//  Revision    : 1.0 - initial release
// ============================================================================
module lc_row_detect
    import tetris_pkg::*;
(
    input  logic [BOARD_CELLS-1:0] i_board,
    output logic [BOARD_ROWS-1:0]  o_full_mask,
    output logic [4:0]             o_full_count
);

    for (genvar r = 0; r < BOARD_ROWS; r++) begin : g_row
        assign o_full_mask[r] = &i_board[r*BOARD_COLS +: BOARD_COLS];
    end

    always_comb begin
        o_full_count = '0;
        for (int r = 0; r < BOARD_ROWS; r++) begin
            o_full_count = o_full_count + {4'd0, o_full_mask[r]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/line_clear_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : line_clear_ctrl
//  Description : Tetris line-clear sequencer. On start it latches the board,
//                finds full rows, blinks them BLINKS times (FLASH_FRAMES
//                frames per phase, frames counted on vs falling edges),
//                collapses the board in 21 cycles and strobes the result.
//  Ports       : clk  - 25 MHz clock, rising edge
//                clrn - asynchronous active-low reset
//                bus  - line_clear_ctrl_if.slave (vs, start, board_in in;
//                       flash, board_out, board_we, busy, done, lines out)
//  Options     : LINE_CLEAR_SCORE_EN - adds saturating 16-bit score output
//  Revision    : 1.0 - initial release
// ============================================================================
module line_clear_ctrl
    import tetris_pkg::*;
#(
    parameter int unsigned FLASH_FRAMES = 8,
    parameter int unsigned BLINKS       = 3
) (
    input  logic             clk,
    input  logic             clrn,
    line_clear_ctrl_if.slave bus
);

    localparam logic [7:0] C_FRAME_LAST = 8'(FLASH_FRAMES - 1);
    localparam logic [4:0] C_BLINKS     = 5'(BLINKS);
    localparam logic [4:0] C_LAST_ROW   = 5'(BOARD_ROWS - 1);

    lc_state_t              state_q,     state_d;
    logic                   vs_q,        vs_d;
    logic [BOARD_CELLS-1:0] board_q,     board_d;
    logic [BOARD_CELLS-1:0] board_out_q, board_out_d;
    logic [BOARD_CELLS-1:0] flash_q,     flash_d;
    logic [BOARD_ROWS-1:0]  mask_q,      mask_d;
    logic [4:0]             lines_q,     lines_d;
    logic [7:0]             frame_q,     frame_d;
    logic [3:0]             blink_q,     blink_d;
    logic [4:0]             cyc_q,       cyc_d;
    logic [4:0]             dst_q,       dst_d;
    logic                   board_we_q,  board_we_d;
    logic                   done_q,      done_d;
    logic                   busy_q,      busy_d;
`ifdef LINE_CLEAR_SCORE_EN
    logic [15:0]            score_q,     score_d;
    logic [16:0]            w_score_sum;
`endif

    logic                   w_tick;
    logic                   w_phase_end;
    logic [4:0]             w_blink_nx;
    logic [4:0]             w_src;
    logic [BOARD_COLS-1:0]  w_src_row;
    logic [BOARD_ROWS-1:0]  w_det_mask;
    logic [4:0]             w_det_count;

    lc_row_detect u_row_detect (
        .i_board      (board_q),
        .o_full_mask  (w_det_mask),
        .o_full_count (w_det_count)
    );

    // vs is active-low: a frame starts when it drops.
    assign w_tick      = vs_q & ~bus.vs;
    assign w_phase_end = w_tick && (frame_q == C_FRAME_LAST);
    assign w_blink_nx  = {1'b0, blink_q} + 5'd1;
    // Collapse walks rows bottom-up; the clear cycle never uses w_src.
    assign w_src       = (cyc_q < 5'(BOARD_ROWS)) ? (C_LAST_ROW - cyc_q) : 5'd0;

    always_comb begin
        w_src_row = '0;
        for (int r = 0; r < BOARD_ROWS; r++) begin
            if (5'(r) == w_src) begin
                w_src_row = board_q[r*BOARD_COLS +: BOARD_COLS];
            end
        end
    end

`ifdef LINE_CLEAR_SCORE_EN
    assign w_score_sum = {1'b0, score_q} + {1'b0, score_add(lines_q)};
`endif

    always_comb begin
        state_d     = state_q;
        vs_d        = bus.vs;
        board_d     = board_q;
        board_out_d = board_out_q;
        mask_d      = mask_q;
        lines_d     = lines_q;
        frame_d     = frame_q;
        blink_d     = blink_q;
        cyc_d       = cyc_q;
        dst_d       = dst_q;
`ifdef LINE_CLEAR_SCORE_EN
        score_d     = score_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    board_d = bus.board_in;
                    state_d = ST_SCAN;
                end
            end

            ST_SCAN: begin
                mask_d  = w_det_mask;
                lines_d = w_det_count;
                frame_d = '0;
                blink_d = '0;
                if (w_det_count == 5'd0) begin
                    board_out_d = board_q;
                    state_d     = ST_DONE;
                end else begin
                    state_d = ST_FLASH_ON;
                end
            end

            ST_FLASH_ON: begin
                if (w_phase_end) begin
                    frame_d = '0;
                    state_d = ST_FLASH_OFF;
                end else if (w_tick) begin
                    frame_d = frame_q + 8'd1;
                end
            end

            ST_FLASH_OFF: begin
                if (w_phase_end) begin
                    frame_d = '0;
                    blink_d = w_blink_nx[3:0];
                    if (w_blink_nx < C_BLINKS) begin
                        state_d = ST_FLASH_ON;
                    end else begin
                        cyc_d   = '0;
                        dst_d   = C_LAST_ROW;
                        state_d = ST_COLLAPSE;
                    end
                end else if (w_tick) begin
                    frame_d = frame_q + 8'd1;
                end
            end

            ST_COLLAPSE: begin
                if (cyc_q < 5'(BOARD_ROWS)) begin
                    cyc_d = cyc_q + 5'd1;
                    // Surviving rows move down in place; dst never falls
                    // below src, so a row is read before it can be overwritten.
                    if (!mask_q[w_src]) begin
                        for (int r = 0; r < BOARD_ROWS; r++) begin
                            if (5'(r) == dst_q) begin
                                board_d[r*BOARD_COLS +: BOARD_COLS] = w_src_row;
                            end
                        end
                        dst_d = dst_q - 5'd1;
                    end
                end else begin
                    // At least one row was full, so dst is a valid row here.
                    for (int r = 0; r < BOARD_ROWS; r++) begin
                        if (5'(r) <= dst_q) begin
                            board_d[r*BOARD_COLS +: BOARD_COLS] = '0;
                        end
                    end
                    board_out_d = board_d;
                    state_d     = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
`ifdef LINE_CLEAR_SCORE_EN
                score_d = w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
`endif
            end

            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered against the next state so they line up
        // with the state they describe.
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DONE);
        board_we_d = (state_d == ST_DONE) && (lines_d != 5'd0);
        flash_d    = (state_d == ST_FLASH_ON) ? expand_rows(mask_d) : '0;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q     <= ST_IDLE;
            vs_q        <= 1'b1;
            board_q     <= '0;
            board_out_q <= '0;
            flash_q     <= '0;
            mask_q      <= '0;
            lines_q     <= '0;
            frame_q     <= '0;
            blink_q     <= '0;
            cyc_q       <= '0;
            dst_q       <= '0;
            board_we_q  <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
`ifdef LINE_CLEAR_SCORE_EN
            score_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            vs_q        <= vs_d;
            board_q     <= board_d;
            board_out_q <= board_out_d;
            flash_q     <= flash_d;
            mask_q      <= mask_d;
            lines_q     <= lines_d;
            frame_q     <= frame_d;
            blink_q     <= blink_d;
            cyc_q       <= cyc_d;
            dst_q       <= dst_d;
            board_we_q  <= board_we_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
`ifdef LINE_CLEAR_SCORE_EN
            score_q     <= score_d;
`endif
        end
    end

    assign bus.flash     = flash_q;
    assign bus.board_out = board_out_q;
    assign bus.board_we  = board_we_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.lines     = lines_q;
`ifdef LINE_CLEAR_SCORE_EN
    assign bus.score     = score_q;
`endif

endmodule
`default_nettype wire

// File: doc/line_clear_ctrl.md
LINE_CLEAR_CTRL -- requirements
Module: line_clear_ctrl

Interface
REQ-001 SHALL have parameter FLASH_FRAMES, default 8: frames per flash phase (on or off), range 1..255.
REQ-002 SHALL have parameter BLINKS, default 3: number of on/off phase pairs before collapse, range 1..15.
REQ-003 SHALL have port clk, input, 1: the single 25 MHz clock; all state SHALL be clocked on its rising edge.
REQ-004 SHALL have port clrn, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port vs, input, 1: VGA vertical sync, active-low and synchronous to clk.
REQ-006 SHALL have port start, input, 1: one-cycle pulse indicating that a piece has locked.
REQ-007 SHALL have port board_in, input, 200: occupancy matrix, bit row*10+col, row 0 at the top.
REQ-008 SHALL have port flash, output, 200: flash mask driven to the display.
REQ-009 SHALL have port board_out, output, 200: compacted matrix.
REQ-010 SHALL have port board_we, output, 1: one-cycle strobe marking board_out valid.
REQ-011 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-012 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-013 SHALL have port lines, output, 5: number of full rows found by the last SCAN.

Function
REQ-014 SHALL generate a frame tick for exactly one cycle per vs falling edge, using one vs history register.
REQ-015 SHALL implement the states IDLE, SCAN, FLASH_ON, FLASH_OFF, COLLAPSE and DONE.
REQ-016 IDLE: on start=1, SHALL latch board_in and go to SCAN on the next cycle; start in any other state SHALL be ignored.
REQ-017 SCAN (1 cycle): SHALL compute a 20-bit full-row mask and its popcount into lines; 0 full rows -> DONE, otherwise -> FLASH_ON with the frame counter cleared.
REQ-018 FLASH_ON: SHALL drive flash = all 10 bits of every full row and 0 elsewhere; after FLASH_FRAMES ticks -> FLASH_OFF.
REQ-019 FLASH_OFF: SHALL drive flash = 0; after FLASH_FRAMES ticks, increment the blink count, then -> FLASH_ON if the count < BLINKS, else -> COLLAPSE.
REQ-020 Frame ticks SHALL be counted only in the FLASH states; the first tick after entering a phase SHALL count as 1.
REQ-021 COLLAPSE SHALL take exactly 21 cycles:
- cycles 0-19: src = 19 down to 0; when row src is not full, copy it to row dst and decrement dst (dst starts at 19).
- cycle 20: clear rows 0..dst.
- then -> DONE.
REQ-022 In COLLAPSE, flash SHALL be 0.
REQ-023 DONE (1 cycle): SHALL assert done=1, and board_we=1 only when lines > 0; board_out SHALL then hold its value until the next DONE; next state IDLE.
REQ-024 start asserted in the same cycle as DONE SHALL be ignored; start on the following cycle (IDLE) SHALL be accepted.
REQ-025 board_in changes after the latch in IDLE SHALL have no effect on the operation in progress.
REQ-026 Row-index and counter arithmetic SHALL be unsigned with no wrap-around; dst SHALL never underflow because at least one row is skipped or cleared.

Reset
REQ-027 clrn=0 SHALL immediately set state=IDLE and flash, board_out, board_we, done, busy, lines, all counters and the vs history register (to 1) to their reset values, including mid-operation.
REQ-028 Reset values SHALL be 0 for every output and for all counters and state registers; the vs history register SHALL reset to 1.
REQ-029 After reset, no spurious frame tick SHALL occur when vs is idle high.

Configuration
REQ-030 SHALL provide macro LINE_CLEAR_SCORE_EN, which adds output score[15:0], reset to 0.
REQ-031 With LINE_CLEAR_SCORE_EN defined, in DONE score SHALL add 1/3/5/8 for lines = 1/2/3/>=4, and saturate at 16'hFFFF.
REQ-032 Without LINE_CLEAR_SCORE_EN, the score port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-033 SHALL use package tetris_pkg containing: BOARD_ROWS=20, BOARD_COLS=10, BOARD_CELLS=200, the state enum lc_state_t, and the score table constants.
REQ-034 SHALL contain one sub-module lc_row_detect: combinational logic producing the 20-bit full-row mask and 5-bit popcount from a 200-bit board.

Verification
REQ-035 The bench SHALL check: board with only row 19 full, start -> SCAN gives lines=1; flash bits 190..199 toggle 3 times at 8-frame phases; then board_out = board shifted down one row with row 0 = 0, board_we=1 for 1 cycle.
REQ-036 The bench SHALL check: empty board, start -> done exactly 2 cycles after start; board_we=0; flash stays 0; lines=0.
REQ-037 The bench SHALL check: rows 5, 10, 18 and 19 full, with an isolated cell at row 17 col 3 -> lines=4; that cell appears at row 19 col 3 after collapse; rows 0..3 = 0; with LINE_CLEAR_SCORE_EN, score += 8.
REQ-038 The bench SHALL check: start pulsed during FLASH_ON and at the DONE cycle -> ignored; start one cycle after DONE -> busy=1 on the next cycle.
REQ-039 The bench SHALL check: clrn=0 mid-COLLAPSE -> all outputs 0 asynchronously; after release, start with row 0 full completes normally.
REQ-040 The bench SHALL check: vs held low across reset release -> no tick is counted until the next falling edge.
